iterative_divider: RTL and testbench

Sequential unsigned restoring divider: the inverse of the team's 2-bit array multiplier. It takes a 2N-bit dividend and an N-bit divisor and produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock. A start/busy/done handshake connects it to a controller or test sequencer. With default N=2, any product the multiplier produces (0..9) divided by either multiplier operand returns the other operand with remainder 0.

---
 rtl/iterative_divider_if.sv | 23 ++
 rtl/iterative_divider.sv | 115 +++++++++++
 tb/tb_iterative_divider.sv | 131 +++++++++++++
 3 files changed

// File: rtl/iterative_divider_if.sv
// Handshake and operand/result bundle between a division controller and iterative_divider.
interface iterative_divider_if #(
  parameter int N = 2
) ();
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module iterative_divider #(
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  iterative_divider_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [N:0]    r;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          dz;
  } dp_t;

  state_t state, state_nx;
  dp_t    dp, dp_nx;

  logic [N:0] t, diff;
  logic       ge, last;

  logic           busy_nx, done_nx, dz_nx;
  logic [W-1:0]   quot_nx;
  logic [N-1:0]   rem_nx;

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    t    = {dp.r[N-1:0], dp.q[W-1]};
    ge   = (t >= {1'b0, dp.d});
    diff = t - {1'b0, dp.d};
    last = (dp.cnt == CW'(W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A zero divisor still spends one cycle in CALC so busy is visible before done.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (dp.dz || last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dp_nx = dp;
    case (state)
      IDLE: if (bus.start) begin
        dp_nx.q   = bus.dividend;
        dp_nx.d   = bus.divisor;
        dp_nx.r   = '0;
        dp_nx.cnt = '0;
        dp_nx.dz  = (bus.divisor == '0);
      end
      CALC: if (!dp.dz) begin
        dp_nx.q   = {dp.q[W-2:0], ge};
        dp_nx.r   = ge ? diff : t;
        dp_nx.cnt = dp.cnt + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp <= '0;
    else        dp <= dp_nx;
  end

  // Outputs are registered from next-state values; results only update on entry to DONE.
  always_comb begin
    busy_nx = (state_nx == CALC);
    done_nx = (state_nx == DONE);
    quot_nx = bus.quotient;
    rem_nx  = bus.remainder;
    dz_nx   = bus.div_by_zero;
    if (state == CALC && state_nx == DONE) begin
      if (dp.dz) begin
        quot_nx = '1;
        rem_nx  = '0;
        dz_nx   = 1'b1;
      end else begin
        quot_nx = dp_nx.q;
        rem_nx  = dp_nx.r[N-1:0];
        dz_nx   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy        <= busy_nx;
      bus.done        <= done_nx;
      bus.quotient    <= quot_nx;
      bus.remainder   <= rem_nx;
      bus.div_by_zero <= dz_nx;
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider (N=2): latency, results, zero divisor, ignored starts, reset.
module tb_iterative_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  always #5 clk = ~clk;

  iterative_divider_if #(.N(2)) bus ();
  iterative_divider #(.N(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && mon_en) chk("busy_done_excl", {31'b0, bus.busy & bus.done}, 32'd0);

  // Start one division, scramble operands after the accept edge, wait for done.
  task automatic do_div(input string tag, input logic [3:0] a, input logic [1:0] b,
                        input int exp_q, input int exp_r, input int exp_dz,
                        input int exp_lat, input int exp_busy);
    int cyc, nbusy;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = ~a; bus.divisor = ~b;
    cyc = 1; nbusy = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_q"}, bus.quotient, exp_q);
    chk({tag, "_r"}, bus.remainder, exp_r);
    chk({tag, "_dz"}, bus.div_by_zero, exp_dz);
    if (exp_busy >= 0) chk({tag, "_busy_cycles"}, nbusy, exp_busy);
    @(negedge clk);
    if (exp_busy >= 0) chk({tag, "_done_fall"}, bus.done, 0);
  endtask

  initial begin
    int cyc, ndone, prev;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;

    do_div("d13_3", 4'd13, 2'd3, 4, 1, 0, 5, 4);
    do_div("d15_1", 4'd15, 2'd1, 15, 0, 0, 5, 4);
    do_div("d2_3",  4'd2,  2'd3, 0, 2, 0, 5, 4);
    do_div("d9_0",  4'd9,  2'd0, 15, 0, 1, 2, 1);
    do_div("d9_2",  4'd9,  2'd2, 4, 1, 0, 5, 4);

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 4; b++)
        do_div("sweep", 4'(a), 2'(b), a / b, a % b, 0, 5, -1);

    for (int x = 0; x < 4; x++)
      for (int y = 1; y < 4; y++)
        do_div("mulinv", 4'(x * y), 2'(y), x, 0, 0, 5, -1);

    // Extra start pulses mid-CALC and during DONE must not launch a second division.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 2'd2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 2'd3;
    @(negedge clk); bus.start = 1'b0;
    cyc = 3;
    while (!bus.done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("ign_lat", cyc, 5);
    chk("ign_q", bus.quotient, 3);
    chk("ign_r", bus.remainder, 0);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("ign_idle_busy", bus.busy, 0);
    @(negedge clk);
    chk("ign_not_queued", bus.busy, 0);
    @(negedge clk);
    chk("ign_no_done", bus.done, 0);
    chk("ign_q_hold", bus.quotient, 3);

    // Reset mid-CALC: outputs clear asynchronously, then normal operation resumes.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 2'd2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    mon_en = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_q", bus.quotient, 0);
    chk("mid_rst_r", bus.remainder, 0);
    chk("mid_rst_dz", bus.div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;
    do_div("d7_2", 4'd7, 2'd2, 3, 1, 0, 5, 4);

    // Continuous start: one result every 6 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 2'd3;
    ndone = 0; prev = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        chk("hold_q", bus.quotient, 4);
        chk("hold_r", bus.remainder, 0);
        chk("hold_spacing", c - prev, (ndone == 1) ? 5 : 6);
        prev = c;
      end
    end
    bus.start = 1'b0;
    chk("hold_count", ndone, 3);

    repeat (8) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
